// File: rtl/gray_pkg.sv
// Shared constants and types for the grayscale pixel scheduler.
// Coefficients are the 8-bit fixed-point BT.601 luma weights (sum = 256).
package gray_pkg;

  localparam int GRAY_KR  = 77;
  localparam int GRAY_KG  = 150;
  localparam int GRAY_KB  = 29;
  localparam int GRAY_RND = 128;

  // Scheduler states: IDLE arbitrates, BURST streams one frame from the grantee.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Drops the 8 fractional bits of the rounded weighted sum. Because the
  // coefficients sum to 256 the integer part always fits in 8 bits.
  function automatic logic [7:0] gray_round(input logic [15:0] sum);
    return sum[15:8];
  endfunction

endpackage

// File: rtl/gray_core.sv
// Two-stage RGB-to-grayscale pipeline.
// Stage 1 registers the three weighted products plus a sideband tag; stage 2
// registers the rounded sum. Both stages advance only when en is high, so the
// whole pipe freezes as a unit under downstream backpressure.
module gray_core
  import gray_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [7:0]       r_i,
  input  logic [7:0]       g_i,
  input  logic [7:0]       b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             mid_valid_o,
  output logic             out_valid_o,
  output logic [7:0]       gray_o
);

  logic [15:0]      prod_r_d, prod_g_d, prod_b_d;
  logic [15:0]      s1_pr_q, s1_pg_q, s1_pb_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_valid_q;

  logic [15:0]      sum_d;
  logic [7:0]       s2_gray_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_valid_q;

  // Largest single product is 150*255 = 38250, and the full rounded sum peaks
  // at 65408, so 16-bit arithmetic never overflows.
  assign prod_r_d = 16'(GRAY_KR) * {8'd0, r_i};
  assign prod_g_d = 16'(GRAY_KG) * {8'd0, g_i};
  assign prod_b_d = 16'(GRAY_KB) * {8'd0, b_i};
  assign sum_d    = s1_pr_q + s1_pg_q + s1_pb_q + 16'(GRAY_RND);

  // Stage 1: capture products and tag; bubbles travel as invalid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pr_q    <= '0;
      s1_pg_q    <= '0;
      s1_pb_q    <= '0;
      s1_tag_q   <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_pr_q  <= prod_r_d;
        s1_pg_q  <= prod_g_d;
        s1_pb_q  <= prod_b_d;
        s1_tag_q <= tag_i;
      end
    end
  end

  // Stage 2 (output register): rounded sum and tag; data only loads on a
  // real pixel so the output bus is quiet across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_gray_q  <= '0;
      s2_tag_q   <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_gray_q <= gray_round(sum_d);
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign mid_valid_o = s1_valid_q;
  assign out_valid_o = s2_valid_q;
  assign gray_o      = s2_gray_q;
  assign tag_o       = s2_tag_q;

endmodule

// File: rtl/gray_pixel_scheduler.sv
// Frame-granular round-robin scheduler sharing one grayscale pipeline
// between NUM_REQ pixel sources.
//
// Handshake: on both the per-source input ports and the output port a pixel
// moves on a rising edge where valid and ready are both high. A producer keeps
// valid and data steady until accepted; ready never depends on anything but
// current state and the downstream out_ready, so there is no comb loop from
// req_valid to req_ready.
module gray_pixel_scheduler
  import gray_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int FRAME_PIXELS = 64,
  parameter int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_red,
  input  logic [8*NUM_REQ-1:0] req_green,
  input  logic [8*NUM_REQ-1:0] req_blue,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_gray,
  output logic [SRC_W-1:0]     out_src,
  output logic                 out_last,
  output logic [SRC_W-1:0]     grant_id,
  output logic                 busy,
  output state_e               dbg_state
);

  localparam int               CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [SRC_W-1:0] PTR_RST  = SRC_W'(NUM_REQ - 1);
  localparam int               TAG_W    = SRC_W + 1;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pipe_en;
  logic             xfer;
  logic             cnt_last;
  logic             win_found;
  logic [SRC_W-1:0] win_id;
  logic [SRC_W-1:0] cand;

  logic [7:0]       red_a   [NUM_REQ];
  logic [7:0]       green_a [NUM_REQ];
  logic [7:0]       blue_a  [NUM_REQ];

  logic [TAG_W-1:0] core_tag_in;
  logic [TAG_W-1:0] core_tag_out;
  logic             core_mid_valid;
  logic             core_out_valid;
  logic [7:0]       core_gray;

  // Split the packed per-source channel buses into per-source bytes.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign red_a[i]   = req_red[8*i +: 8];
    assign green_a[i] = req_green[8*i +: 8];
    assign blue_a[i]  = req_blue[8*i +: 8];
  end

  // The pipe stalls only when a finished pixel is parked at the output.
  assign pipe_en  = !(core_out_valid && !out_ready);
  assign xfer     = |(req_valid & req_ready);
  assign cnt_last = (cnt_q == CNT_LAST);

  // Round-robin search starting one past the previous grantee, so a source
  // whose burst just ended ranks last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // State register plus grant pointer and in-burst pixel counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= PTR_RST;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, count accepted pixels in BURST and leave
  // on the frame's final transfer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d      = BURST;
          grant_d      = win_id;
          last_grant_d = win_id;
          cnt_d        = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          if (cnt_last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: only the grantee sees ready, and only while the pipe can move.
  always_comb begin
    req_ready = '0;
    if (state_q == BURST) begin
      req_ready[grant_q] = pipe_en;
    end
  end

  assign core_tag_in = {cnt_last, grant_q};

  gray_core #(
    .TAG_W (TAG_W)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (pipe_en),
    .in_valid    (xfer),
    .r_i         (red_a[grant_q]),
    .g_i         (green_a[grant_q]),
    .b_i         (blue_a[grant_q]),
    .tag_i       (core_tag_in),
    .tag_o       (core_tag_out),
    .mid_valid_o (core_mid_valid),
    .out_valid_o (core_out_valid),
    .gray_o      (core_gray)
  );

  assign out_valid = core_out_valid;
  assign out_gray  = core_gray;
  assign out_src   = core_tag_out[SRC_W-1:0];
  assign out_last  = core_tag_out[SRC_W];
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE) || core_mid_valid || core_out_valid;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_pixel_scheduler.sv
// Bench for gray_pixel_scheduler: instance a uses FRAME_PIXELS=4 with a
// scoreboard, instance b uses FRAME_PIXELS=1 with fixed per-source pixels.
module tb_gray_pixel_scheduler;
  import gray_pkg::*;

  localparam int NR = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance a (FRAME_PIXELS=4) ----------------
  logic [NR-1:0]   a_valid, a_ready;
  logic [8*NR-1:0] a_red, a_green, a_blue;
  logic            a_ovalid, a_oready, a_last, a_busy;
  logic [7:0]      a_gray;
  logic [0:0]      a_src, a_grant;
  state_e          a_state;

  gray_pixel_scheduler #(.NUM_REQ(NR), .FRAME_PIXELS(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_valid),
    .req_ready (a_ready),
    .req_red   (a_red),
    .req_green (a_green),
    .req_blue  (a_blue),
    .out_valid (a_ovalid),
    .out_ready (a_oready),
    .out_gray  (a_gray),
    .out_src   (a_src),
    .out_last  (a_last),
    .grant_id  (a_grant),
    .busy      (a_busy),
    .dbg_state (a_state)
  );

  // ---------------- instance b (FRAME_PIXELS=1) ----------------
  logic [NR-1:0]   b_valid, b_ready;
  logic [8*NR-1:0] b_red, b_green, b_blue;
  logic            b_ovalid, b_oready, b_last, b_busy;
  logic [7:0]      b_gray;
  logic [0:0]      b_src, b_grant;
  state_e          b_state;

  // source 0 = (200,100,50) -> 124, source 1 = (30,60,90) -> 54
  assign b_red   = {8'd30, 8'd200};
  assign b_green = {8'd60, 8'd100};
  assign b_blue  = {8'd90, 8'd50};

  gray_pixel_scheduler #(.NUM_REQ(NR), .FRAME_PIXELS(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_valid),
    .req_ready (b_ready),
    .req_red   (b_red),
    .req_green (b_green),
    .req_blue  (b_blue),
    .out_valid (b_ovalid),
    .out_ready (b_oready),
    .out_gray  (b_gray),
    .out_src   (b_src),
    .out_last  (b_last),
    .grant_id  (b_grant),
    .busy      (b_busy),
    .dbg_state (b_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gray_model(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int s;
    s = 77 * r + 150 * g + 29 * b + 128;
    return 8'(s >> 8);
  endfunction

  // ---------------- pixel source model for instance a ----------------
  int pc [NR] = '{0, 0};
  logic [NR-1:0] a_xf = '0;

  function automatic logic [23:0] pat(input int i, input int p);
    logic [7:0] tr [4];
    logic [7:0] tg [4];
    logic [7:0] tb [4];
    tr = '{8'd255, 8'd100, 8'd0, 8'd10};
    tg = '{8'd255, 8'd150, 8'd0, 8'd20};
    tb = '{8'd255, 8'd50,  8'd0, 8'd30};
    if (i == 0 && p < 4) return {tr[p], tg[p], tb[p]};
    return {8'(p * 37 + i * 11), 8'(p * 53 + i * 7 + 3), 8'(p * 19 + i * 101)};
  endfunction

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      logic [23:0] px;
      px = pat(i, pc[i]);
      a_red[8*i +: 8]   = px[23:16];
      a_green[8*i +: 8] = px[15:8];
      a_blue[8*i +: 8]  = px[7:0];
    end
  end

  // advance a source's pixel index after the edge that accepted it
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (a_xf[i]) pc[i] <= pc[i] + 1;
    end
  end

  // ---------------- scoreboard / monitors ----------------
  logic [9:0] exp_q[$];
  int bcnt = 0;
  int a_tx = 0, a_first_tx = -1, a_last_tx = -1, a_first_out = -1;
  bit count_gaps = 0;
  int gap_stop = 0, gaps = 0;
  logic [0:0] hist_src[$];
  logic       hist_last[$];
  logic [7:0] hist_gray[$];

  always @(negedge clk) begin
    logic last_e;
    for (int i = 0; i < NR; i++) a_xf[i] = a_valid[i] && a_ready[i];
    if (count_gaps && a_tx >= 1 && a_tx < gap_stop && a_ready == '0) gaps++;
    for (int i = 0; i < NR; i++) begin
      if (a_xf[i]) begin
        last_e = (bcnt == 3);
        bcnt   = last_e ? 0 : bcnt + 1;
        exp_q.push_back({1'(i), last_e,
                         gray_model(a_red[8*i +: 8], a_green[8*i +: 8], a_blue[8*i +: 8])});
        a_tx++;
        if (a_tx == 1) a_first_tx = cyc;
        a_last_tx = cyc;
      end
    end
    if (a_ovalid && a_oready) begin
      hist_src.push_back(a_src);
      hist_last.push_back(a_last);
      hist_gray.push_back(a_gray);
      if (a_first_out < 0) a_first_out = cyc;
      if (exp_q.size() == 0) check("sb_extra_pixel", 32'(hist_src.size()), 32'(0));
      else check("sb_pixel", 32'({a_src, a_last, a_gray}), 32'(exp_q.pop_front()));
    end
  end

  int b_tx = 0, b_first_tx = -1, b_last_tx = -1;
  logic [0:0] h1_src[$];
  logic       h1_last[$];
  logic [7:0] h1_gray[$];

  always @(negedge clk) begin
    if ((b_valid & b_ready) != '0) begin
      b_tx++;
      if (b_tx == 1) b_first_tx = cyc;
      b_last_tx = cyc;
    end
    if (b_ovalid && b_oready) begin
      h1_src.push_back(b_src);
      h1_last.push_back(b_last);
      h1_gray.push_back(b_gray);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_tx(input bit use_b, input int n, input int budget);
    int k;
    k = 0;
    while (((use_b ? b_tx : a_tx) < n) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(use_b ? "b_tx_timeout" : "a_tx_timeout", 32'((use_b ? b_tx : a_tx) >= n), 32'(1));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((a_busy || b_busy || exp_q.size() != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", 32'(a_busy || b_busy || exp_q.size() != 0), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n   = 1'b0;
    a_valid = '0;
    b_valid = '0;
    exp_q.delete();
    bcnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic clear_hist();
    hist_src.delete();
    hist_last.delete();
    hist_gray.delete();
    a_tx = 0;
    a_first_tx = -1;
    a_first_out = -1;
  endtask

  task automatic check_hist(input string tag, input int k, input int exp_src, input bit exp_last);
    if (k < hist_src.size()) begin
      check({tag, "_src"},  32'(hist_src[k]),  32'(exp_src));
      check({tag, "_last"}, 32'(hist_last[k]), 32'(exp_last));
    end else begin
      check({tag, "_count"}, 32'(hist_src.size()), 32'(k + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(a_ready),  32'(0));
    check({tag, "_ovalid"}, 32'(a_ovalid), 32'(0));
    check({tag, "_gray"},   32'(a_gray),   32'(0));
    check({tag, "_src"},    32'(a_src),    32'(0));
    check({tag, "_last"},   32'(a_last),   32'(0));
    check({tag, "_grant"},  32'(a_grant),  32'(0));
    check({tag, "_busy"},   32'(a_busy),   32'(0));
    check({tag, "_state"},  32'(a_state),  32'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [7:0] t1_gray [4];

  initial begin
    a_valid  = '0;
    b_valid  = '0;
    a_oready = 1'b1;
    b_oready = 1'b1;
    t1_gray  = '{8'd255, 8'd124, 8'd0, 8'd18};

    // reset values
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("rst");
    check("rst_b_busy", 32'(b_busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single source, directed pixels, latency
    clear_hist();
    a_valid = 2'b01;
    wait_tx(0, 4, 40);
    a_valid = '0;
    wait_idle(40);
    check("t1_count", 32'(hist_src.size()), 32'(4));
    for (int k = 0; k < 4; k++) begin
      check_hist("t1", k, 0, k == 3);
      check("t1_gray", (k < hist_gray.size()) ? 32'(hist_gray[k]) : 32'hdead, 32'(t1_gray[k]));
    end
    check("t1_latency", 32'(a_first_out - a_first_tx), 32'(2));

    // 2: both sources continuously valid
    do_reset();
    clear_hist();
    gaps = 0;
    gap_stop = 12;
    count_gaps = 1;
    a_valid = 2'b11;
    wait_tx(0, 12, 60);
    a_valid = '0;
    count_gaps = 0;
    wait_idle(40);
    check("t2_count", 32'(hist_src.size()), 32'(12));
    for (int k = 0; k < 12; k++) check_hist("t2", k, (k / 4 == 1) ? 1 : 0, (k % 4) == 3);
    check("t2_gaps", 32'(gaps), 32'(2));
    check("t2_span", 32'(a_last_tx - a_first_tx), 32'(13));

    // 3: output backpressure for 5 cycles mid-burst
    clear_hist();
    a_valid = 2'b01;
    wait_tx(0, 2, 20);
    a_oready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_ovalid", 32'(a_ovalid), 32'(1));
      check("t3_ready", 32'(a_ready), 32'(0));
      check("t3_hold", 32'({a_src, a_last, a_gray}),
            (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hdead);
    end
    @(posedge clk); #1;
    a_oready = 1'b1;
    wait_tx(0, 4, 30);
    a_valid = '0;
    wait_idle(40);
    check("t3_count", 32'(hist_src.size()), 32'(4));
    for (int k = 0; k < 4; k++) check_hist("t3", k, 0, k == 3);

    // 4: source 1 alone, then source 0 joins mid-burst
    clear_hist();
    a_valid = 2'b10;
    @(negedge clk);
    check("t4_idle_ready", 32'(a_ready), 32'(0));
    check("t4_idle_state", 32'(a_state), 32'(IDLE));
    @(negedge clk);
    check("t4_grant", 32'(a_grant), 32'(1));
    check("t4_ready", 32'(a_ready), 32'(2));
    @(posedge clk); #1;
    a_valid = 2'b11;
    wait_tx(0, 8, 60);
    a_valid = '0;
    wait_idle(40);
    check("t4_count", 32'(hist_src.size()), 32'(8));
    for (int k = 0; k < 8; k++) check_hist("t4", k, (k < 4) ? 1 : 0, (k % 4) == 3);

    // 5: asynchronous reset after 2 of 4 pixels
    clear_hist();
    a_valid = 2'b01;
    wait_tx(0, 2, 20);
    check("t5_pre_ovalid", 32'(a_ovalid), 32'(1));
    rst_n   = 1'b0;
    a_valid = '0;
    #1;
    check_reset_outputs("t5_rst");
    exp_q.delete();
    bcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_hist();
    a_valid = 2'b11;
    wait_tx(0, 4, 20);
    a_valid = '0;
    wait_idle(40);
    check("t5_count", 32'(hist_src.size()), 32'(4));
    for (int k = 0; k < 4; k++) check_hist("t5", k, 0, k == 3);

    // 6: FRAME_PIXELS=1 instance, both sources valid
    b_tx = 0;
    h1_src.delete();
    h1_last.delete();
    h1_gray.delete();
    b_valid = 2'b11;
    wait_tx(1, 8, 40);
    b_valid = '0;
    wait_idle(40);
    check("t6_count", 32'(h1_src.size()), 32'(8));
    for (int k = 0; k < 8; k++) begin
      check("t6_src",  (k < h1_src.size())  ? 32'(h1_src[k])  : 32'hdead, 32'(k % 2));
      check("t6_last", (k < h1_last.size()) ? 32'(h1_last[k]) : 32'hdead, 32'(1));
      check("t6_gray", (k < h1_gray.size()) ? 32'(h1_gray[k]) : 32'hdead,
            (k % 2 == 1) ? 32'(54) : 32'(124));
    end
    check("t6_span", 32'(b_last_tx - b_first_tx), 32'(14));

    check("end_sb_empty", 32'(exp_q.size()), 32'(0));
    check("end_a_busy", 32'(a_busy), 32'(0));
    check("end_b_busy", 32'(b_busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
